// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t        : FSM state encoding (IDLE=00, RUN=01, DONE=10; 11 is illegal)
//   count_bits()   : width of the bit counter for a given operand width
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
   // The floor of 1 keeps the vector legal for the smallest widths.
   function automatic int count_bits(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serial_adder_badd.sv
// bAdd: single-bit full adder used as the arithmetic core of the serial adder.
// Ports:
//   a, b   : operand bits
//   c_in   : carry in
//   sum    : a ^ b ^ c_in
//   c_out  : majority(a, b, c_in)
module bAdd (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder that processes one bit per clock through a
// single full-adder cell. Operands are shifted in LSB-first, the carry is held
// in a flip-flop between bits, and sum bits collect in a shift register until
// the last bit, when the full result is transferred to the output registers.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request; accepted in IDLE or DONE, ignored while busy
//   a, b   : operands, sampled on an accepted start
//   c_in   : carry in, sampled on an accepted start
//   busy   : high while in RUN
//   done   : single-cycle pulse in DONE; sum/c_out valid from then on
//   sum    : registered result, held until the next completion or reset
//   c_out  : registered final carry, held like sum
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = count_bits(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    sa_reg, sa_next;
   logic [WIDTH-1:0]    sb_reg, sb_next;
   logic                carry_reg, carry_next;
   logic [CW-1:0]       count_reg, count_next;
   // Only WIDTH-1 bits need storing: the final sum bit goes straight to the
   // output register on the completing edge.
   logic [WIDTH-2:0]    shift_reg, shift_next;
   logic [WIDTH-1:0]    sum_reg, sum_next;
   logic                c_out_reg, c_out_next;

   logic                fa_sum;
   logic                fa_c_out;
   logic [WIDTH-1:0]    result_word;

   bAdd u_fa (
      .a     (sa_reg[0]),
      .b     (sb_reg[0]),
      .c_in  (carry_reg),
      .sum   (fa_sum),
      .c_out (fa_c_out)
   );

   // Current sum bit entering at the MSB of the collected bits. Its top
   // WIDTH-1 bits are the next shift register contents; on the last bit the
   // whole word is the finished result.
   assign result_word = {fa_sum, shift_reg};

   always_comb begin
      state_next = state_reg;
      sa_next    = sa_reg;
      sb_next    = sb_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      shift_next = shift_reg;
      sum_next   = sum_reg;
      c_out_next = c_out_reg;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sa_next    = a;
               sb_next    = b;
               carry_next = c_in;
               count_next = '0;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end

         ST_RUN: begin
            sa_next    = sa_reg >> 1;
            sb_next    = sb_reg >> 1;
            carry_next = fa_c_out;
            shift_next = result_word[WIDTH-1:1];
            if (count_reg == LAST_BIT) begin
               // Last bit: publish the complete result and carry together.
               sum_next   = result_word;
               c_out_next = fa_c_out;
               state_next = ST_DONE;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end

         default: begin
            // Unreachable encoding; return to a known state.
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         shift_reg <= '0;
         sum_reg   <= '0;
         c_out_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         sa_reg    <= sa_next;
         sb_reg    <= sb_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
         sum_reg   <= sum_next;
         c_out_reg <= c_out_next;
      end
   end

   assign busy  = (state_reg == ST_RUN);
   assign done  = (state_reg == ST_DONE);
   assign sum   = sum_reg;
   assign c_out = c_out_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   int last_done_cycle = 0;

   // Reference state: what the result registers should currently hold.
   logic [WIDTH-1:0] held_sum  = '0;
   logic             held_cout = 1'b0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // One addition starting from IDLE or DONE. inject_cycle (1..WIDTH) raises
   // start with different operands during RUN; it must have no effect.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input int inject_cycle);
      logic [WIDTH:0] expv;
      expv = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
      a = av; b = bv; c_in = cv; start = 1'b1;
      tick;
      // Scramble inputs: operands must have been captured at accept.
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
      for (int k = 1; k <= WIDTH; k++) begin
         if (k == inject_cycle) begin
            start = 1'b1; a = 8'h01; b = WIDTH'($urandom);
         end else begin
            start = 1'b0;
         end
         check("busy_in_run", busy, 1'b1);
         check("no_done_in_run", done, 1'b0);
         check("sum_held_in_run", sum, held_sum);
         check("cout_held_in_run", c_out, held_cout);
         tick;
      end
      start = 1'b0;
      check("done_pulse", done, 1'b1);
      check("busy_low_at_done", busy, 1'b0);
      check("sum_result", sum, expv[WIDTH-1:0]);
      check("cout_result", c_out, expv[WIDTH]);
      held_sum  = expv[WIDTH-1:0];
      held_cout = expv[WIDTH];
      last_done_cycle = cycle;
      $display("op a=%h b=%h c_in=%0d inject=%0d -> sum=%h c_out=%0d (expected %h/%0d) at cycle %0d",
               av, bv, cv, inject_cycle, sum, c_out, expv[WIDTH-1:0], expv[WIDTH], cycle);
   endtask

   task automatic idle_cycle;
      tick;
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_sum_held", sum, held_sum);
      check("idle_cout_held", c_out, held_cout);
   endtask

   initial begin
      int d1;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_sum", sum, 0);
      check("reset_cout", c_out, 1'b0);
      $display("reset applied at cycle %0d", cycle);
      idle_cycle();

      // Directed cases
      run_op(8'h5A, 8'h33, 1'b0, 0);
      idle_cycle();
      run_op(8'hFF, 8'h01, 1'b0, 0);
      idle_cycle();
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      idle_cycle();
      run_op(8'h12, 8'h34, 1'b0, 3);   // start while busy, ignored
      idle_cycle();

      // Back-to-back: second start in the done cycle of the first
      run_op(8'h10, 8'h20, 1'b0, 0);
      d1 = last_done_cycle;
      run_op(8'h7F, 8'h01, 1'b0, 0);
      check("back_to_back_spacing", last_done_cycle - d1, WIDTH + 1);
      idle_cycle();

      // Reset mid-operation: rst in cycle 4, no done afterwards
      a = 8'hC3; b = 8'h5C; c_in = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check("busy_before_reset", busy, 1'b1);
         tick;
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      held_sum = '0; held_cout = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", c_out, 1'b0);
      $display("reset mid-operation at cycle %0d", cycle);
      for (int k = 0; k < WIDTH + 2; k++) idle_cycle();

      // Reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
      tick;
      rst = 1'b0; start = 1'b0;
      check("rst_over_start_busy", busy, 1'b0);
      $display("reset with start at cycle %0d", cycle);
      idle_cycle();

      // Randomised operations with random gaps and ignored restarts
      for (int n = 0; n < 24; n++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                int'($urandom_range(WIDTH + 2, 0)));
         if ($urandom_range(1, 0) == 1) idle_cycle();
      end
      run_op(8'h00, 8'h00, 1'b0, 0);
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
